// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR filter: one multiply-accumulate per clock over a TAPS-deep
// circular sample history, producing a rounded, saturated result per accepted sample.
module fir_mac_filter #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned COEF_WIDTH = 18,
   parameter int unsigned TAPS       = 16,
   parameter int unsigned FRAC_BITS  = 16,
   parameter logic [TAPS*COEF_WIDTH-1:0] COEFS = {16{18'sd4096}}
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic                         valid_i,
   input  logic signed [DATA_WIDTH-1:0] data_i,
   output logic signed [DATA_WIDTH-1:0] data_o,
   output logic                         valid_o,
   output logic                         busy_o,
   output logic                         overrun_o
);

   localparam int unsigned PTR_W  = $clog2(TAPS);
   localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;
   localparam int unsigned ACC_W  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS);
   localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (FRAC_BITS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                       state_q, state_d;
   logic signed [DATA_WIDTH-1:0] hist_q [TAPS];
   logic signed [DATA_WIDTH-1:0] hist_d [TAPS];
   logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]             k_q, k_d;
   logic signed [ACC_W-1:0]      acc_q, acc_d;
   logic signed [DATA_WIDTH-1:0] data_q, data_d;
   logic                         valid_q, valid_d;
   logic                         busy_q, busy_d;
   logic                         overrun_q, overrun_d;

   logic signed [COEF_WIDTH-1:0] coef;
   logic signed [DATA_WIDTH-1:0] sample;
   logic signed [PROD_W-1:0]     prod;
   logic signed [ACC_W-1:0]      rnd;
   logic signed [DATA_WIDTH-1:0] sat;

   // Datapath: current tap product and rounded/saturated accumulator view.
   always_comb begin
      coef   = $signed(COEFS[32'(k_q)*COEF_WIDTH +: COEF_WIDTH]);
      sample = hist_q[rd_ptr_q];
      prod   = sample * coef;
      rnd    = (acc_q + HALF) >>> FRAC_BITS;
      if (rnd > SAT_MAX)      sat = SAT_MAX[DATA_WIDTH-1:0];
      else if (rnd < SAT_MIN) sat = SAT_MIN[DATA_WIDTH-1:0];
      else                    sat = rnd[DATA_WIDTH-1:0];
   end

   always_comb begin
      state_d   = state_q;
      hist_d    = hist_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      k_d       = k_q;
      acc_d     = acc_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               hist_d[wr_ptr_q] = data_i;
               rd_ptr_d = wr_ptr_q;
               wr_ptr_d = (wr_ptr_q == PTR_W'(TAPS-1)) ? '0 : wr_ptr_q + PTR_W'(1);
               acc_d    = '0;
               k_d      = '0;
               state_d  = MAC;
            end
         end
         MAC: begin
            overrun_d = valid_i;
            acc_d     = acc_q + ACC_W'(prod);
            // Walk backwards through history: x[n-k].
            rd_ptr_d  = (rd_ptr_q == '0) ? PTR_W'(TAPS-1) : rd_ptr_q - PTR_W'(1);
            if (k_q == PTR_W'(TAPS-1)) begin
               k_d     = '0;
               state_d = OUT;
            end else begin
               k_d = k_q + PTR_W'(1);
            end
         end
         OUT: begin
            overrun_d = valid_i;
            data_d    = sat;
            valid_d   = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= IDLE;
         for (int i = 0; i < int'(TAPS); i++) hist_q[i] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         k_q       <= k_d;
         acc_q     <= acc_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign busy_o    = busy_q;
   assign overrun_o = overrun_q;

endmodule
